cheri_err_monitor: RTL

CHERI_ERR_MONITOR -- requirements
Module: cheri_err_monitor

---
 rtl/cheri_err_pkg.sv | 33 +++
 rtl/cheri_err_stretch.sv | 32 +++
 rtl/cheri_err_monitor.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cheri_err_pkg.sv
// Shared types for the CHERI error monitor: channel enumeration, report FSM state, helpers.
// Latency: none (package only).
// Backpressure: not applicable.
package cheri_err_pkg;

  localparam int CheriErrWidth = 9;

  typedef enum logic [3:0] {
    Bounds              = 4'd0,
    Tag                 = 4'd1,
    Seal                = 4'd2,
    PermitExecute       = 4'd3,
    PermitLoad          = 4'd4,
    PermitStore         = 4'd5,
    PermitStoreCap      = 4'd6,
    PermitStoreLocalCap = 4'd7,
    PermitAccSysRegs    = 4'd8
  } cheri_err_e;

  typedef enum logic {
    IDLE   = 1'b0,
    REPORT = 1'b1
  } rpt_state_e;

  // Index of the lowest set bit (0 when nothing is set; callers gate on |v).
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    lowest_set = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_set = 5'(i);
    end
  endfunction

endpackage

// File: rtl/cheri_err_stretch.sv
// Per-channel LED stretcher: holds o_led high for StretchCycles clocks after each event.
// Latency: o_led rises the clock after i_evt; a new event reloads the full on-time.
// Backpressure: none; i_clear zeroes the stretch immediately.
module cheri_err_stretch import cheri_err_pkg::*; #(
  parameter int StretchCycles = 3_000_000,
  localparam int CW = $clog2(StretchCycles + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_evt,
  output logic o_led
);

  logic [CW-1:0] r_cnt;

  // Reload on event, otherwise count down to zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_evt) begin
      r_cnt <= CW'(StretchCycles);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_led = (r_cnt != '0);

endmodule

// File: rtl/cheri_err_monitor.sv
// CHERI error monitor: edge-detects error lines, keeps sticky/counters, reports first occurrences.
// Latency: rise sampled at edge N -> sticky after N, report_valid_o after N+1; rd_cnt_o 1 cycle.
// Backpressure: report held stable while report_ready_i=0; events keep accruing as pending bits.
// Build option: define CHERI_ERR_STRETCH_EN to drive led_o from per-channel stretchers
// instead of sticky_o.
module cheri_err_monitor import cheri_err_pkg::*; #(
  parameter int ErrWidth      = CheriErrWidth,
  parameter int CntWidth      = 16,
  parameter int StretchCycles = 3_000_000,
  localparam int IdxW = (ErrWidth > 1) ? $clog2(ErrWidth) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ErrWidth-1:0] err_i,
  input  logic                clear_i,
  output logic                report_valid_o,
  input  logic                report_ready_i,
  output logic [IdxW-1:0]     report_idx_o,
  output logic [ErrWidth-1:0] sticky_o,
  input  logic [IdxW-1:0]     rd_idx_i,
  output logic [CntWidth-1:0] rd_cnt_o,
  output logic [ErrWidth-1:0] led_o
);

  logic [ErrWidth-1:0] r_err_q;
  logic [ErrWidth-1:0] r_sticky;
  logic [ErrWidth-1:0] r_pending;
  logic [CntWidth-1:0] r_cnt [ErrWidth];
  logic [CntWidth-1:0] r_rd_cnt;
  rpt_state_e          r_state;
  rpt_state_e          w_state_nxt;
  logic [IdxW-1:0]     r_idx;
  logic [IdxW-1:0]     w_idx_nxt;

  logic [ErrWidth-1:0] w_evt;
  logic                w_xfer;
  logic [ErrWidth-1:0] w_xfer_mask;
  logic [ErrWidth-1:0] w_pending_left;

  assign w_evt          = err_i & ~r_err_q;
  assign report_valid_o = (r_state == REPORT);
  assign w_xfer         = report_valid_o & report_ready_i;
  assign w_xfer_mask    = w_xfer ? (ErrWidth'(1) << r_idx) : '0;
  assign w_pending_left = r_pending & ~w_xfer_mask;

  assign report_idx_o = r_idx;
  assign sticky_o     = r_sticky;
  assign rd_cnt_o     = r_rd_cnt;

  // Registered copy of the raw lines; keeps tracking through clear so no false rise follows.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_err_q <= '0;
    else       r_err_q <= err_i;
  end

  // Sticky and pending bits; only the first event since clear makes a channel pending.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sticky  <= '0;
      r_pending <= '0;
    end else if (clear_i) begin
      r_sticky  <= '0;
      r_pending <= '0;
    end else begin
      r_sticky  <= r_sticky | w_evt;
      r_pending <= w_pending_left | (w_evt & ~r_sticky);
    end
  end

  // Per-channel saturating event counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < ErrWidth; e++) r_cnt[e] <= '0;
    end else begin
      for (int e = 0; e < ErrWidth; e++) begin
        if (clear_i) begin
          r_cnt[e] <= '0;
        end else if (w_evt[e] && (r_cnt[e] != '1)) begin
          r_cnt[e] <= r_cnt[e] + CntWidth'(1);
        end
      end
    end
  end

  // Counter read port; out-of-range selects read as zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_cnt <= '0;
    end else if (int'(rd_idx_i) < ErrWidth) begin
      r_rd_cnt <= r_cnt[rd_idx_i];
    end else begin
      r_rd_cnt <= '0;
    end
  end

  // Report FSM state and latched report index.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state: enter REPORT on any pending bit, step to the next lowest pending on transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (clear_i) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|r_pending) begin
            w_state_nxt = REPORT;
            w_idx_nxt   = IdxW'(lowest_set(32'(r_pending)));
          end
        end
        REPORT: begin
          if (w_xfer) begin
            if (|w_pending_left) begin
              w_idx_nxt = IdxW'(lowest_set(32'(w_pending_left)));
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

`ifdef CHERI_ERR_STRETCH_EN
  for (genvar e = 0; e < ErrWidth; e++) begin : g_stretch
    cheri_err_stretch #(
      .StretchCycles(StretchCycles)
    ) u_stretch (
      .i_clk  (clk_i),
      .i_rst  (rst_i),
      .i_clear(clear_i),
      .i_evt  (w_evt[e]),
      .o_led  (led_o[e])
    );
  end
`else
  assign led_o = r_sticky;
  logic w_unused_stretch;
  assign w_unused_stretch = (StretchCycles == 0);
`endif

endmodule
